usi_bus_master: RTL

- Initiator end of the USI CSR bus.
- Accepts single read/write commands from a command source (sequencer/CPU bridge) over a valid/ready port.
- Drives write data, address and write-enable to the CSR slaves, collects the slaves' read data/valid, and returns one response per read.
- Sits between the processor-side command path and the per-block CSR slaves (GPIO, etc.).

---
 rtl/usi_bus_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/usi_bus_master.sv
// usi_bus_master -- initiator end of the USI CSR bus.
//
// Accepts single read/write commands over a valid/ready port, drives the
// registered bus (address, write data, write enable) to the CSR slaves,
// collects slave read data/valid and returns one response per read.
//
// Ports:
//   iSysClk, iSysRst            clock, asynchronous active-low reset
//   iCmdVd/oCmdRdy              command handshake (ready only in IDLE)
//   iCmdWr, iCmdAdrs, iCmdWd    command direction, address, write data
//   oRspVd/iRspRdy              response handshake
//   oRspRd, oRspErr             response data, timeout error flag
//   oMUsiWd, oMUsiAdrs,
//   oMUsiWCke                   registered bus write data/address/write enable
//   iMUsiRd, iMUsiVd            slave read data and valid
//   oBusy                       high in any state except IDLE
//
// Optional feature macro: USI_MASTER_WR_ACK_EN
//   defined   -> each write returns a response carrying the write data
//   undefined -> writes are posted, no response
module usi_bus_master #(
  parameter int unsigned             pBusAdrsBit = 32,
  parameter int unsigned             pTimeout    = 16,
  parameter logic [pBusAdrsBit-1:0]  pIdleAdrs   = '0
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic                   iCmdVd,
  output logic                   oCmdRdy,
  input  logic                   iCmdWr,
  input  logic [pBusAdrsBit-1:0] iCmdAdrs,
  input  logic [31:0]            iCmdWd,
  output logic                   oRspVd,
  input  logic                   iRspRdy,
  output logic [31:0]            oRspRd,
  output logic                   oRspErr,
  output logic [31:0]            oMUsiWd,
  output logic [pBusAdrsBit-1:0] oMUsiAdrs,
  output logic                   oMUsiWCke,
  input  logic [31:0]            iMUsiRd,
  input  logic                   iMUsiVd,
  output logic                   oBusy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

  // Last wait-counter value before the timeout fires; the counter starts
  // at 0 in the first READ cycle, so this gives pTimeout READ cycles.
  localparam logic [7:0] CntLast = 8'(pTimeout - 1);

  state_t                   state_q, state_d;
  logic [pBusAdrsBit-1:0]   adrs_q, adrs_d;
  logic [31:0]              wd_q, wd_d;
  logic                     wcke_q, wcke_d;
  logic                     rspvd_q, rspvd_d;
  logic [31:0]              rsprd_q, rsprd_d;
  logic                     rsperr_q, rsperr_d;
  logic [7:0]               cnt_q, cnt_d;

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      state_q  <= ST_IDLE;
      adrs_q   <= pIdleAdrs;
      wd_q     <= '0;
      wcke_q   <= 1'b0;
      rspvd_q  <= 1'b0;
      rsprd_q  <= '0;
      rsperr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adrs_q   <= adrs_d;
      wd_q     <= wd_d;
      wcke_q   <= wcke_d;
      rspvd_q  <= rspvd_d;
      rsprd_q  <= rsprd_d;
      rsperr_q <= rsperr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bus outputs are registered, so the values for a state are loaded on
  // the transition into it.
  always_comb begin
    state_d  = state_q;
    adrs_d   = adrs_q;
    wd_d     = wd_q;
    wcke_d   = wcke_q;
    rspvd_d  = rspvd_q;
    rsprd_d  = rsprd_q;
    rsperr_d = rsperr_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        adrs_d = pIdleAdrs;
        wd_d   = '0;
        wcke_d = 1'b0;
        if (iCmdVd) begin
          adrs_d = iCmdAdrs;
          if (iCmdWr) begin
            state_d = ST_WRITE;
            wd_d    = iCmdWd;
            wcke_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            cnt_d   = '0;
          end
        end
      end

      ST_WRITE: begin
        // Single WCke cycle: slaves write on every cycle it is high.
        adrs_d = pIdleAdrs;
        wd_d   = '0;
        wcke_d = 1'b0;
`ifdef USI_MASTER_WR_ACK_EN
        state_d  = ST_RESP;
        rspvd_d  = 1'b1;
        rsprd_d  = wd_q;
        rsperr_d = 1'b0;
`else
        state_d  = ST_IDLE;
`endif
      end

      ST_READ: begin
        // cnt_q == 0 marks the first READ cycle, where slave valid cannot
        // yet reflect this address.
        if ((cnt_q != 8'd0) && iMUsiVd) begin
          state_d  = ST_RESP;
          adrs_d   = pIdleAdrs;
          rspvd_d  = 1'b1;
          rsprd_d  = iMUsiRd;
          rsperr_d = 1'b0;
        end else if (cnt_q >= CntLast) begin
          state_d  = ST_RESP;
          adrs_d   = pIdleAdrs;
          rspvd_d  = 1'b1;
          rsprd_d  = '0;
          rsperr_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        if (iRspRdy) begin
          state_d = ST_IDLE;
          rspvd_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign oCmdRdy   = (state_q == ST_IDLE);
  assign oBusy     = (state_q != ST_IDLE);
  assign oRspVd    = rspvd_q;
  assign oRspRd    = rsprd_q;
  assign oRspErr   = rsperr_q;
  assign oMUsiWd   = wd_q;
  assign oMUsiAdrs = adrs_q;
  assign oMUsiWCke = wcke_q;

endmodule
